// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Outputs are decoded from the state register; pc_en also folds in the ALU zero flag.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic       illegal_op,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e state_q, state_d;

    // Raw versions of the outputs that reset must squash.
    logic pc_write_s, ir_write_s, reg_write_s, mem_write_s, mem_read_s, illegal_s;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write_s    = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        illegal_s     = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_RTYPE:        state_d = S_EXECUTE;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ORI, OP_ADDI: state_d = S_IMM_EXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                i_or_d     = 1'b1;
                state_d    = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                i_or_d      = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = 2'b10;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ORI) ? 2'b00 : 2'b11;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_write   = pc_write_s  & rst_n;
    assign ir_write   = ir_write_s  & rst_n;
    assign reg_write  = reg_write_s & rst_n;
    assign mem_write  = mem_write_s & rst_n;
    assign mem_read   = mem_read_s  & rst_n;
    assign illegal_op = illegal_s   & rst_n;
    assign pc_en      = rst_n & (pc_write_s | (pc_write_cond & zero));
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed and random stimulus for the multicycle control FSM against an instruction-path model.
module tb_mips_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    int es = 0;
    int path[$];

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, ORI = 6'b001101, ADDI = 6'b001000, BADOP = 6'b111111;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .illegal_op(illegal_op), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .state(state)
    );

    always #5 clk = ~clk;

    // Expected outputs for a state, straight from the per-state output table.
    function automatic logic [21:0] model_out(input int s, input logic [5:0] op,
                                              input logic mr, input logic z, input logic rn);
        logic pw, pwc, pe, iod, mrd, mwr, m2r, irw, rw, rd, asa, ill;
        logic [1:0] ps, ao, asb;
        logic [3:0] st;
        {pw, pwc, pe, iod, mrd, mwr, m2r, irw, rw, rd, asa, ill} = '0;
        ps = 2'b00; ao = 2'b00; asb = 2'b00;
        st = 4'(s);
        case (s)
            0:  begin mrd = 1; asb = 2'b01; ao = 2'b11; irw = mr; pw = mr; end
            1:  begin asb = 2'b11; ao = 2'b11;
                      ill = !(op inside {RT, LW, SW, BEQ, JMP, ORI, ADDI}); end
            2:  begin asa = 1; asb = 2'b10; ao = 2'b11; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin asa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; ao = (op == ORI) ? 2'b00 : 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        if (!rn) {pw, irw, rw, mwr, mrd, ill} = '0;
        pe = rn & (pw | (pwc & z));
        return {pw, pwc, pe, iod, mrd, mwr, m2r, irw, rw, rd, asa, ill, ps, ao, asb, st};
    endfunction

    task automatic cyc(input logic rn, input logic [5:0] op, input logic mr, input logic z,
                       input string tag);
        logic [21:0] exp_v, obs_v;
        @(negedge clk);
        rst_n = rn; opcode = op; mem_ready = mr; zero = z;
        #1;
        exp_v = model_out(es, op, mr, z, rn);
        obs_v = {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, mem_to_reg,
                 ir_write, reg_write, reg_dst, alu_src_a, illegal_op, pc_source, alu_op,
                 alu_src_b, state};
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s: model_state=%0d observed=%h expected=%h", tag, es, obs_v, exp_v);
        end
        // Advance the model along the instruction's state path.
        if (!rn) begin
            es = 0;
            path.delete();
        end else if (es == 0) begin
            es = mr ? 1 : 0;
        end else if (es == 1) begin
            path.delete();
            case (op)
                LW:        path = '{2, 3, 4};
                SW:        path = '{2, 5};
                RT:        path = '{6, 7};
                BEQ:       path = '{8};
                JMP:       path = '{9};
                ORI, ADDI: path = '{10, 11};
                default:   ;
            endcase
            es = (path.size() > 0) ? path.pop_front() : 0;
        end else if ((es == 3 || es == 5) && !mr) begin
            es = es;
        end else begin
            es = (path.size() > 0) ? path.pop_front() : 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Cycles from FETCH until the DUT is back in FETCH, with mem_ready held high.
    task automatic lat(input logic [5:0] op, input int expn, input string tag);
        int n;
        n = 0;
        do begin
            cyc(1'b1, op, 1'b1, 1'($urandom_range(0, 1)), tag);
            n++;
        end while (state != 4'd0 && n < 12);
        total++;
        assert (n === expn) else begin
            bad++;
            $error("FAIL %s_latency: observed=%0d expected=%0d", tag, n, expn);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops[7];
        legal_ops = '{RT, LW, SW, BEQ, JMP, ORI, ADDI};
        op = RT;

        cyc(1'b0, RT, 1'b1, 1'b0, "reset0");
        cyc(1'b0, RT, 1'b0, 1'b1, "reset1");

        lat(RT, 4, "rtype");
        lat(LW, 5, "lw");
        lat(SW, 4, "sw");
        lat(ORI, 4, "ori");
        lat(ADDI, 4, "addi");
        lat(BEQ, 3, "beq");
        lat(JMP, 3, "j");
        lat(BADOP, 2, "illegal");

        // Fetch stall, then lw with a three-cycle read wait.
        cyc(1'b1, LW, 1'b0, 1'b0, "fetch_wait");
        cyc(1'b1, LW, 1'b1, 1'b0, "lw_fetch");
        cyc(1'b1, LW, 1'b0, 1'b0, "lw_decode");
        cyc(1'b1, LW, 1'b0, 1'b0, "lw_addr");
        for (int i = 0; i < 3; i++) cyc(1'b1, LW, 1'b0, 1'b0, "lw_read_wait");
        cyc(1'b1, LW, 1'b1, 1'b0, "lw_read_done");
        cyc(1'b1, LW, 1'b0, 1'b0, "lw_wb");

        // beq taken then not taken.
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, BEQ, 1'b1, 1'b0, "beq_fetch");
            cyc(1'b1, BEQ, 1'b1, 1'b0, "beq_decode");
            cyc(1'b1, BEQ, 1'b1, (k == 0), "beq_branch");
        end

        // Reset while stalled in MEM_WRITE.
        cyc(1'b1, SW, 1'b1, 1'b0, "sw_fetch");
        cyc(1'b1, SW, 1'b1, 1'b0, "sw_decode");
        cyc(1'b1, SW, 1'b1, 1'b0, "sw_addr");
        cyc(1'b1, SW, 1'b0, 1'b0, "sw_wait");
        cyc(1'b0, SW, 1'b0, 1'b0, "sw_reset");
        cyc(1'b1, SW, 1'b0, 1'b0, "post_reset");

        for (int i = 0; i < 2000; i++) begin
            if (es == 0) begin
                if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 6)];
                else op = 6'($urandom);
            end
            cyc(($urandom_range(0, 63) != 0), op, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26], held stable by the instruction register from DECODE onward.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completion handshake.
REQ-006 SHALL have these outputs, 1 bit each: pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, illegal_op.
REQ-007 SHALL have outputs pc_source, alu_op and alu_src_b, 2 bits each.
REQ-008 SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-009 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11; codes 12-15 SHALL return to FETCH on the next edge.
REQ-010 SHALL use this alu_op encoding, which is fixed by the ALU control decoder: 00=OR, 01=SUB, 10=R-type funct decode, 11=ADD.
REQ-011 SHALL drive every output not listed for the current state to 0.
REQ-012 In FETCH: mem_read=1, alu_src_b=01, alu_op=11, ir_write=mem_ready, pc_write=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-013 In DECODE: alu_src_b=11, alu_op=11 (branch target). Next state by opcode:
- 100011 (lw), 101011 (sw) -> MEM_ADDR
- 000000 -> EXECUTE
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001101 (ori), 001000 (addi) -> IMM_EXEC
- any other opcode -> FETCH, with illegal_op=1 for this single cycle
REQ-014 In MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11; go to MEM_READ for lw, MEM_WRITE for sw.
REQ-015 In MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then go to MEM_WB.
REQ-016 In MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then go to FETCH.
REQ-017 In MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then go to FETCH.
REQ-018 In EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; then go to R_WB.
REQ-019 In R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then go to FETCH.
REQ-020 In BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then go to FETCH.
REQ-021 In JUMP: pc_write=1, pc_source=10; then go to FETCH.
REQ-022 In IMM_EXEC: alu_src_a=1, alu_src_b=10; alu_op=00 for ori, 11 for addi; then go to IMM_WB.
REQ-023 In IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then go to FETCH.
REQ-024 pc_en SHALL equal pc_write OR (pc_write_cond AND zero), combinationally, at all times.
REQ-025 With mem_ready=1 throughout, latency in cycles per instruction: lw 5; sw, R-type, ori, addi 4; beq, j 3; illegal 2.
REQ-026 mem_ready SHALL be ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-027 A rising edge of clk with rst_n=0 SHALL set state=FETCH, in any state, including during a memory wait.
REQ-028 While rst_n=0, pc_write, pc_en, ir_write, reg_write, mem_write, mem_read and illegal_op SHALL be forced to 0 combinationally.
REQ-029 On the first edge with rst_n=1, the FSM SHALL evaluate FETCH normally.

Verification
REQ-030 Reset, then opcode=000000 and mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write=1 and reg_dst=1 only in R_WB.
REQ-031 lw (100011) with mem_ready=0 for 3 cycles in MEM_READ -> FSM holds state=3 for 4 cycles with mem_read=1 and i_or_d=1, then one cycle of MEM_WB with reg_write=1 and mem_to_reg=1.
REQ-032 beq (000100) with zero=1 -> pc_en=1 in BRANCH with alu_op=01; repeat with zero=0 -> pc_en=0 in BRANCH.
REQ-033 ori (001101) -> alu_op=00 in IMM_EXEC; addi (001000) -> alu_op=11 in IMM_EXEC; reg_write=1 in IMM_WB.
REQ-034 opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then state=0, with no reg_write or mem_write asserted.
REQ-035 rst_n=0 asserted while in MEM_WRITE with mem_ready=0 -> mem_write=0 immediately, state=0 after the next edge.
